// File: rtl/UART_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding.
package UART_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/uart_rx.sv
// Serial-to-parallel UART receiver: synchronises rx, finds start bits, samples
// each bit at its centre and presents every word with a one-cycle valid pulse.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV = (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);
  localparam logic          PAR_ON    = (PARITY_EN != 0);

  UART_pkg::state_t state;

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_d;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic                 fall;
  logic [SW-1:0]        s;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 perr;
  logic                 done;

  assign tick = (tick_cnt == TICK_LAST);
  assign fall = rx_d & ~rx_s;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Oversample tick generator, phase-locked to each detected start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if ((state == UART_pkg::IDLE) && fall) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Once s is re-zeroed at the middle of the start bit, every later wrap of s
  // lands a full bit period on, i.e. at the centre of the next bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= UART_pkg::IDLE;
      s          <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      perr       <= 1'b0;
      done       <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_valid <= done;
      case (state)
        UART_pkg::IDLE: begin
          if (fall) begin
            state <= UART_pkg::START;
            s     <= '0;
            busy  <= 1'b1;
          end
        end
        UART_pkg::START: begin
          if (tick) begin
            if (s == S_MID) begin
              if (rx_s) begin
                state <= UART_pkg::IDLE;
                busy  <= 1'b0;
              end else begin
                state   <= UART_pkg::DATA;
                s       <= '0;
                bit_cnt <= '0;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        UART_pkg::DATA: begin
          if (tick) begin
            if (s == S_LAST) begin
              s     <= '0;
              shift <= {rx_s, shift[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                state <= PAR_ON ? UART_pkg::PARITY : UART_pkg::STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        UART_pkg::PARITY: begin
          if (tick) begin
            if (s == S_LAST) begin
              s     <= '0;
              perr  <= rx_s ^ (^shift) ^ ODD;
              state <= UART_pkg::STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        UART_pkg::STOP: begin
          if (tick) begin
            if (s == S_LAST) begin
              s          <= '0;
              rx_data    <= shift;
              parity_err <= PAR_ON & perr;
              frame_err  <= ~rx_s;
              done       <= 1'b1;
              state      <= UART_pkg::IDLE;
              busy       <= 1'b0;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: begin
          state <= UART_pkg::IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
